// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame
// geometry and the parity helper used by both receiver and transmitter.
package uart_pkg;

   localparam int DEF_DATA_BITS  = 8;
   localparam int DEF_OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      START    = 3'd1,
      DATA     = 3'd2,
      PARITY   = 3'd3,
      STOP     = 3'd4,
      BRK_WAIT = 3'd5
   } rx_state_e;

   // Parity bit for a frame of up to 8 data bits (unused upper bits must be 0).
   // odd = 1 gives odd parity, odd = 0 gives even parity.
   function automatic logic parity_bit(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: a down-counter that reloads from the divisor
// and pulses o_tick on its terminal count. While i_hold is high the counter
// sits at the reload value so the first tick is a full period after release.
module uart_baud_tick #(
   parameter int DIV_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_hold,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_tick
);

   logic [DIV_W-1:0] r_cnt;

   // Count down, reloading on terminal count or while held.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_hold || (r_cnt == '0)) begin
         r_cnt <= i_div;
      end else begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_tick = !i_hold && (r_cnt == '0);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises RX, detects the start edge, samples each bit
// at mid-period using an oversample tick, checks parity and stop bit, and
// hands the byte plus error flags upstream through a one-entry holding
// register with a valid/ready handshake.
//
// Handshake: rx_valid high means rx_data/rx_frame_err/rx_parity_err are
// held stable; a transfer happens on any PCLK edge where rx_valid and
// rx_ready are both high. A frame completing while the holder is full and
// not being drained is dropped and flagged by a one-cycle rx_overrun.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = DEF_DATA_BITS,
   parameter int OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int DIV_W      = 16
) (
   input  logic                 PCLK,
   input  logic                 PRESETn,
   input  logic [DIV_W-1:0]     baud_div,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 RX,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   output logic                 rx_overrun,
   output logic                 rx_busy,
   output rx_state_e            rx_state
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   logic                 r_rx_meta, r_rxs, r_rxs_d;
   rx_state_e            r_state, w_state_nxt;
   logic [TW-1:0]        r_tick_cnt, w_tick_nxt;
   logic [BW-1:0]        r_bit_cnt, w_bit_nxt;
   logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
   logic                 r_perr, w_perr_nxt;
   logic [DIV_W-1:0]     r_div;
   logic                 r_par_en, r_par_odd;
   logic [DIV_W-1:0]     w_div_sel;
   logic                 w_hold, w_tick, w_done, w_ferr;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid, r_frame_err, r_parity_err, r_overrun;

   // Two-flop synchroniser plus one delayed copy for falling-edge detection.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_rx_meta <= 1'b1;
         r_rxs     <= 1'b1;
         r_rxs_d   <= 1'b1;
      end else begin
         r_rx_meta <= RX;
         r_rxs     <= r_rx_meta;
         r_rxs_d   <= r_rxs;
      end
   end

   // Track the configuration while idle; it freezes once a frame starts.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_div     <= '0;
         r_par_en  <= 1'b0;
         r_par_odd <= 1'b0;
      end else if (r_state == IDLE) begin
         r_div     <= baud_div;
         r_par_en  <= parity_en;
         r_par_odd <= parity_odd;
      end
   end

   assign w_hold    = (r_state == IDLE);
   assign w_div_sel = w_hold ? baud_div : r_div;

   uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
      .i_clk   (PCLK),
      .i_rst_n (PRESETn),
      .i_hold  (w_hold),
      .i_div   (w_div_sel),
      .o_tick  (w_tick)
   );

   // FSM state, oversample/bit counters, shift register and pending parity error.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state    <= IDLE;
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_perr     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_tick_cnt <= w_tick_nxt;
         r_bit_cnt  <= w_bit_nxt;
         r_shift    <= w_shift_nxt;
         r_perr     <= w_perr_nxt;
      end
   end

   // Next-state logic: mid-bit sampling of start, data, parity and stop bits.
   always_comb begin
      w_state_nxt = r_state;
      w_tick_nxt  = r_tick_cnt;
      w_bit_nxt   = r_bit_cnt;
      w_shift_nxt = r_shift;
      w_perr_nxt  = r_perr;
      w_done      = 1'b0;
      w_ferr      = 1'b0;
      case (r_state)
         IDLE: begin
            w_tick_nxt = '0;
            w_bit_nxt  = '0;
            if (!r_rxs && r_rxs_d) begin
               w_state_nxt = START;
               w_perr_nxt  = 1'b0;
            end
         end
         START: if (w_tick) begin
            if (r_tick_cnt == HALF_LAST) begin
               w_tick_nxt  = '0;
               w_state_nxt = r_rxs ? IDLE : DATA;
            end else begin
               w_tick_nxt = r_tick_cnt + 1'b1;
            end
         end
         DATA: if (w_tick) begin
            if (r_tick_cnt == FULL_LAST) begin
               w_tick_nxt             = '0;
               w_shift_nxt[r_bit_cnt] = r_rxs;
               if (r_bit_cnt == BIT_LAST) begin
                  w_state_nxt = r_par_en ? PARITY : STOP;
               end else begin
                  w_bit_nxt = r_bit_cnt + 1'b1;
               end
            end else begin
               w_tick_nxt = r_tick_cnt + 1'b1;
            end
         end
         PARITY: if (w_tick) begin
            if (r_tick_cnt == FULL_LAST) begin
               w_tick_nxt  = '0;
               w_state_nxt = STOP;
               if (r_rxs != parity_bit(8'(r_shift), r_par_odd)) begin
                  w_perr_nxt = 1'b1;
               end
            end else begin
               w_tick_nxt = r_tick_cnt + 1'b1;
            end
         end
         STOP: if (w_tick) begin
            if (r_tick_cnt == FULL_LAST) begin
               w_tick_nxt  = '0;
               w_done      = 1'b1;
               w_ferr      = !r_rxs;
               w_state_nxt = r_rxs ? IDLE : BRK_WAIT;
            end else begin
               w_tick_nxt = r_tick_cnt + 1'b1;
            end
         end
         BRK_WAIT: begin
            if (r_rxs) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Holding register: load a completed frame if empty or draining, else flag overrun.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_data       <= '0;
         r_valid      <= 1'b0;
         r_frame_err  <= 1'b0;
         r_parity_err <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (w_done) begin
            if (!r_valid || rx_ready) begin
               r_data       <= r_shift;
               r_frame_err  <= w_ferr;
               r_parity_err <= r_perr;
               r_valid      <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_valid && rx_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign rx_data       = r_data;
   assign rx_valid      = r_valid;
   assign rx_frame_err  = r_frame_err;
   assign rx_parity_err = r_parity_err;
   assign rx_overrun    = r_overrun;
   assign rx_busy       = (r_state != IDLE);
   assign rx_state      = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frame table, randomized frames against a
// bit-counting reference model, and hand sequences for glitch, break,
// overrun and reset-during-frame.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int DB = 8;
   localparam int OS = 16;
   localparam int DW = 16;

   logic          PCLK = 1'b0;
   logic          PRESETn = 1'b0;
   logic [DW-1:0] baud_div = '0;
   logic          parity_en = 1'b0;
   logic          parity_odd = 1'b0;
   logic          RX = 1'b1;
   logic          rx_ready = 1'b1;
   logic [DB-1:0] rx_data;
   logic          rx_valid, rx_frame_err, rx_parity_err, rx_overrun, rx_busy;
   rx_state_e     rx_state;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc_cnt  = 0;
   int valid_cyc = 0;
   int ovr_cnt  = 0;
   logic [9:0] exp_q[$];   // {parity_err, frame_err, data}

   uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS), .DIV_W(DW)) dut (
      .PCLK          (PCLK),
      .PRESETn       (PRESETn),
      .baud_div      (baud_div),
      .parity_en     (parity_en),
      .parity_odd    (parity_odd),
      .RX            (RX),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .rx_frame_err  (rx_frame_err),
      .rx_parity_err (rx_parity_err),
      .rx_overrun    (rx_overrun),
      .rx_busy       (rx_busy),
      .rx_state      (rx_state)
   );

   // Clock and cycle counter.
   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) cyc_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every accepted frame must match the head of exp_q.
   always @(negedge PCLK) begin
      if (PRESETn && rx_overrun) ovr_cnt++;
      if (PRESETn && rx_valid && rx_ready) begin
         valid_cyc = cyc_cnt;
         check("frame_pending", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            check("frame", {22'd0, rx_parity_err, rx_frame_err, rx_data}, {22'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge PCLK);
         #1;
      end
   endtask

   // Drive one frame; the configuration is scrambled after the start edge to
   // show it is only taken at the start of a frame. RX is left at the stop value.
   task automatic send_frame(input logic [7:0] data, input int div, input logic pen,
                             input logic podd, input logic pbit, input logic stop);
      int cyc;
      cyc        = OS * (div + 1);
      baud_div   = DW'(div);
      parity_en  = pen;
      parity_odd = podd;
      RX = 1'b0;
      wait_cyc(cyc / 2);
      baud_div   = DW'($urandom_range(0, 255));
      parity_en  = ~pen;
      parity_odd = ~podd;
      wait_cyc(cyc - cyc / 2);
      for (int b = 0; b < DB; b++) begin
         RX = data[b];
         wait_cyc(cyc);
      end
      if (pen) begin
         RX = pbit;
         wait_cyc(cyc);
      end
      RX = stop;
      wait_cyc(cyc);
      baud_div   = DW'(div);
      parity_en  = pen;
      parity_odd = podd;
   endtask

   typedef struct {
      logic [7:0] data;
      int         div;
      logic       pen, podd, pbit, stop;
      logic [7:0] e_data;
      logic       e_perr, e_ferr;
   } vec_t;

   vec_t vecs[9];
   int   t0, lat, nominal, gap;
   logic [7:0] d;
   int   dv;
   logic pen, podd, pbit, stp, e_perr;

   initial begin
      vecs[0] = '{8'hA5, 3, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{8'h3C, 3, 1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
      vecs[2] = '{8'h3C, 3, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0};
      vecs[3] = '{8'h3C, 2, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
      vecs[4] = '{8'h00, 1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[5] = '{8'hFF, 0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
      vecs[6] = '{8'h80, 3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[7] = '{8'h01, 1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
      vecs[8] = '{8'hC3, 0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b1};

      // Reset
      baud_div = DW'(3);
      @(posedge PCLK);
      #1;
      wait_cyc(4);
      check("rst_data", 32'(rx_data), 32'h0);
      check("rst_valid", 32'(rx_valid), 32'h0);
      check("rst_frame_err", 32'(rx_frame_err), 32'h0);
      check("rst_parity_err", 32'(rx_parity_err), 32'h0);
      check("rst_overrun", 32'(rx_overrun), 32'h0);
      check("rst_busy", 32'(rx_busy), 32'h0);
      check("rst_state", 32'(rx_state), 32'(IDLE));
      PRESETn = 1'b1;
      wait_cyc(20);

      // Directed frame table with latency bound
      foreach (vecs[i]) begin
         exp_q.push_back({vecs[i].e_perr, vecs[i].e_ferr, vecs[i].e_data});
         t0 = cyc_cnt;
         send_frame(vecs[i].data, vecs[i].div, vecs[i].pen, vecs[i].podd, vecs[i].pbit, vecs[i].stop);
         RX = 1'b1;
         wait_cyc(OS * (vecs[i].div + 1));
         check("vec_delivered", 32'(exp_q.size()), 32'd0);
         lat     = valid_cyc - t0;
         nominal = (2 * (1 + DB + int'(vecs[i].pen)) + 1) * (OS / 2) * (vecs[i].div + 1);
         check("latency_min", 32'(lat > nominal), 32'd1);
         check("latency_max", 32'(lat <= nominal + vecs[i].div + 6), 32'd1);
      end

      // Randomized frames against the reference model
      for (int i = 0; i < 12; i++) begin
         d    = 8'($urandom_range(0, 255));
         dv   = $urandom_range(0, 3);
         pen  = 1'($urandom_range(0, 1));
         podd = 1'($urandom_range(0, 1));
         pbit = 1'($urandom_range(0, 1));
         stp  = ($urandom_range(0, 5) != 0);
         e_perr = pen && (((($countones(d) + int'(pbit)) % 2) == 1) != podd);
         exp_q.push_back({e_perr, ~stp, d});
         send_frame(d, dv, pen, podd, pbit, stp);
         RX  = 1'b1;
         gap = $urandom_range(1, 2);
         wait_cyc(gap * OS * (dv + 1));
         check("rand_delivered", 32'(exp_q.size()), 32'd0);
      end

      // Glitch on idle line: false start, no output
      baud_div = DW'(3);
      RX = 1'b0;
      wait_cyc(10);
      check("glitch_busy", 32'(rx_busy), 32'd1);
      wait_cyc(10);
      RX = 1'b1;
      wait_cyc(100);
      check("glitch_idle", 32'(rx_busy), 32'd0);
      check("glitch_no_valid", 32'(rx_valid), 32'd0);

      // Framing error followed by a long break: exactly one frame
      exp_q.push_back({1'b0, 1'b1, 8'h55});
      send_frame(8'h55, 3, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_cyc(3 * 10 * 64);
      check("brk_state", 32'(rx_state), 32'(BRK_WAIT));
      check("brk_one_frame", 32'(exp_q.size()), 32'd0);
      RX = 1'b1;
      wait_cyc(64);
      check("brk_exit", 32'(rx_busy), 32'd0);

      // Overrun: second back-to-back frame dropped while holder is full
      rx_ready = 1'b0;
      ovr_cnt  = 0;
      send_frame(8'h11, 3, 1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(8'h22, 3, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_cyc(64);
      check("ovr_valid", 32'(rx_valid), 32'd1);
      check("ovr_data", 32'(rx_data), 32'h11);
      check("ovr_pulses", 32'(ovr_cnt), 32'd1);
      exp_q.push_back({1'b0, 1'b0, 8'h11});
      rx_ready = 1'b1;
      wait_cyc(1);
      check("ovr_drain", 32'(rx_valid), 32'd0);
      check("ovr_popped", 32'(exp_q.size()), 32'd0);

      // Reset during data bit 4, then a clean frame
      baud_div = DW'(3);
      RX = 1'b0;
      wait_cyc(64);
      for (int b = 0; b < 4; b++) begin
         RX = b[0];
         wait_cyc(64);
      end
      RX = 1'b0;
      wait_cyc(32);
      PRESETn = 1'b0;
      RX = 1'b1;
      wait_cyc(4);
      PRESETn = 1'b1;
      wait_cyc(2);
      check("rstmid_valid", 32'(rx_valid), 32'd0);
      check("rstmid_busy", 32'(rx_busy), 32'd0);
      check("rstmid_data", 32'(rx_data), 32'h0);
      wait_cyc(64);
      exp_q.push_back({1'b0, 1'b0, 8'h7E});
      send_frame(8'h7E, 3, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_cyc(64);
      check("rstmid_delivered", 32'(exp_q.size()), 32'd0);
      check("rstmid_final_data", 32'(rx_data), 32'h7E);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- APB-clocked UART receiver: deserialises the asynchronous serial line RX into parallel bytes.
- Used by the peripheral datapath alongside the existing transmitter that drives Tx.
- Flags framing, parity and overrun errors; hands data upstream over a valid/ready handshake through a one-entry holding register.

Parameters:
- DATA_BITS, 8, data bits per frame (5..8), LSB first.
- OVERSAMPLE, 16, baud ticks per bit period; even, >= 8.
- DIV_W, 16, width of the baud divisor input.

Ports:
- PCLK  input  1  system clock.
- PRESETn  input  1  asynchronous active-low reset.
- baud_div  input  DIV_W  PCLK cycles per oversample tick, minus 1; sampled only in IDLE.
- parity_en  input  1  1 = a parity bit follows the data bits.
- parity_odd  input  1  1 = odd parity, 0 = even parity.
- RX  input  1  serial line; idles high; asynchronous to PCLK.
- rx_data  output  DATA_BITS  received byte; valid while rx_valid = 1.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts the held byte.
- rx_frame_err  output  1  stop bit sampled as 0; qualified by rx_valid.
- rx_parity_err  output  1  parity mismatch; qualified by rx_valid.
- rx_overrun  output  1  one-cycle pulse when a completed frame is dropped.
- rx_busy  output  1  FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync deassert):
  - Outputs: rx_data = 0; rx_valid, rx_frame_err, rx_parity_err, rx_overrun, rx_busy = 0.
  - Synchroniser flops reset to 1; FSM = IDLE; all counters = 0.
- RX passes through a 2-FF synchroniser, so internal rxs lags RX by 2 PCLK.
- Tick generator:
  - Down-counter reloads with baud_div and pulses tick when it reaches 0.
  - It is held at reload while in IDLE, so phase aligns to the start edge.
  - baud_div = 0 gives a tick every cycle.
- IDLE: when rxs = 0 (falling edge vs. previous rxs = 1), go to START with tick_cnt = 0.
- START: at tick OVERSAMPLE/2 - 1 (mid-bit), sample rxs.
  - rxs = 1: false start, return to IDLE with no output and no error.
  - rxs = 0: go to DATA with bit_cnt = 0, tick_cnt = 0.
- DATA:
  - Every OVERSAMPLE ticks, sample rxs into the shift register at bit position bit_cnt; update the running XOR.
  - After DATA_BITS samples, go to PARITY if parity_en, else STOP.
- PARITY: sample once.
  - Expected bit = XOR(data) ^ parity_odd.
  - Mismatch sets the pending parity_err.
- STOP: sample once.
  - rxs = 0 sets the pending frame_err; go to BRK_WAIT.
  - rxs = 1: go to IDLE.
  - Either way, complete the frame in the same cycle.
  - Returning from mid-stop permits back-to-back frames.
- BRK_WAIT: stay until rxs = 1, then go to IDLE. A break condition yields exactly one frame with frame_err.
- Frame completion:
  - If rx_valid = 0, or rx_valid & rx_ready in the same cycle: on the next edge load rx_data and both error flags, and set rx_valid = 1.
  - Otherwise, keep the old data and flags and pulse rx_overrun for 1 cycle.
- Handshake:
  - rx_valid clears on the cycle after rx_valid & rx_ready, unless a new load occurs in that cycle.
  - rx_data is stable while rx_valid = 1.
- parity_en, parity_odd and baud_div are latched at the start edge; changes mid-frame have no effect.
- Latency: from the RX mid-stop sample to rx_valid is 1 PCLK, plus the 2-cycle synchroniser.
- Reset mid-frame: the frame is discarded and no flags are raised.

Decomposition:
- Package uart_pkg:
  - rx_state_e enum: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
  - Default constants: DATA_BITS, OVERSAMPLE.
  - Parity-compute function shared with the transmitter.
- Sub-module uart_baud_tick: divisor counter with a hold input; reusable by the transmitter.

Test Plan:
- Clean frame: baud_div = 3, no parity, send 0xA5 (64 PCLK/bit) -> rx_valid with rx_data = 0xA5 about 9.5 bit-times after the start edge; both error flags 0.
- Odd parity: parity_en = 1, parity_odd = 1.
  - Send 0x3C with parity bit 1 -> parity_err = 0.
  - Send 0x3C with parity bit 0 -> rx_parity_err = 1, rx_data = 0x3C.
- Framing and break: send 0x55 with stop = 0, then hold RX low for 3 frames -> one frame with rx_frame_err = 1; no further frames until RX returns high.
- Glitch: 20-PCLK low pulse on idle RX (shorter than half a bit) -> no rx_valid; rx_busy returns to 0.
- Overrun: rx_ready = 0, send 0x11 then 0x22 back-to-back -> rx_data stays 0x11 and rx_overrun pulses once. Then assert rx_ready -> rx_valid drops next cycle.
- Reset mid-frame: assert PRESETn = 0 during DATA bit 4, release, then send 0x7E -> only 0x7E is delivered, with no error flags.
